// File: rtl/ir_line_tracker.sv
// ir_line_tracker: multi-channel IR line sensor synchroniser, debouncer and transition counter
module ir_line_tracker #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 4,
  parameter bit SATURATE = 1'b1,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DB_W    = $clog2(DEBOUNCE + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  raw_black,
  input  logic [N_CH-1:0]  clr,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [N_CH-1:0]  line_state,
  output logic [N_CH-1:0]  edge_pulse,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_flag,
  output logic             any_black
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [N_CH-1:0]  sync1, sync2, differ, done, inc, flag;
  logic [DB_W-1:0]  db_cnt [N_CH];
  logic [CNT_W-1:0] count  [N_CH];
  // Per channel: synced level disagrees with state; debounce completes this edge; white->black
  always_comb begin
    differ = sync2 ^ line_state;
    for (int i = 0; i < N_CH; i++) done[i] = differ[i] && db_cnt[i] == DB_W'(DEBOUNCE - 1);
    inc = done & ~line_state;
  end
  // Synchroniser, debounce, state, pulse, counters and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      line_state <= '0;
      edge_pulse <= '0;
      flag <= '0;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      sync1 <= raw_black;
      sync2 <= sync1;
      line_state <= line_state ^ done;
      edge_pulse <= inc;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt[i] <= (differ[i] && !done[i]) ? db_cnt[i] + 1'b1 : '0;
        count[i] <= clr[i] ? {{(CNT_W-1){1'b0}}, inc[i]}
                  : !inc[i] ? count[i]
                  : count[i] == MAX ? (SATURATE ? MAX : '0)
                  : count[i] + 1'b1;
        flag[i] <= !clr[i] && (flag[i] || (inc[i] && count[i] == MAX));
      end
    end
  end
  // Zero-latency indexed read of registered count/flag; out-of-range reads as zero
  always_comb begin
    rd_count = (32'(rd_sel) < N_CH) ? count[rd_sel] : '0;
    rd_flag = (32'(rd_sel) < N_CH) ? flag[rd_sel] : 1'b0;
    any_black = |line_state;
  end
endmodule

// File: tb/tb_ir_line_tracker.sv
// tb_ir_line_tracker: directed self-checking bench for ir_line_tracker
module tb_ir_line_tracker;
  logic clock = 1'b0;
  logic reset;
  logic [3:0] raw_black, clr;
  logic [1:0] sel_a, sel_s, sel_w;
  logic [3:0] ls_a, ep_a;
  logic [2:0] ls_s, ep_s, ls_w, ep_w;
  logic [7:0] cnt_a;
  logic [1:0] cnt_s, cnt_w;
  logic flag_a, flag_s, flag_w, any_a, any_s, any_w;
  int compared = 0, mismatched = 0;

  always #5 clock = ~clock;

  ir_line_tracker #(.N_CH(4), .CNT_W(8), .DEBOUNCE(4), .SATURATE(1'b1)) dut_a (
    .clock(clock), .reset(reset), .raw_black(raw_black), .clr(clr), .rd_sel(sel_a),
    .line_state(ls_a), .edge_pulse(ep_a), .rd_count(cnt_a), .rd_flag(flag_a), .any_black(any_a));
  ir_line_tracker #(.N_CH(3), .CNT_W(2), .DEBOUNCE(4), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset(reset), .raw_black(raw_black[2:0]), .clr(clr[2:0]), .rd_sel(sel_s),
    .line_state(ls_s), .edge_pulse(ep_s), .rd_count(cnt_s), .rd_flag(flag_s), .any_black(any_s));
  ir_line_tracker #(.N_CH(3), .CNT_W(2), .DEBOUNCE(4), .SATURATE(1'b0)) dut_w (
    .clock(clock), .reset(reset), .raw_black(raw_black[2:0]), .clr(clr[2:0]), .rd_sel(sel_w),
    .line_state(ls_w), .edge_pulse(ep_w), .rd_count(cnt_w), .rd_flag(flag_w), .any_black(any_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw_black = '0;
    clr = '0;
    tick(2);
    reset = 1'b0;
  endtask

  // One full black then white excursion; 8 cycles each is well past the 6-edge latency
  task automatic stripe(input int ch, input int n);
    repeat (n) begin
      raw_black[ch] = 1'b1;
      tick(8);
      raw_black[ch] = 1'b0;
      tick(8);
    end
  endtask

  initial begin
    sel_a = 0; sel_s = 0; sel_w = 0;
    do_reset();
    // Idle white: nothing moves
    tick(20);
    check("idle_state", ls_a, 0);
    check("idle_any", any_a, 0);
    check("idle_pulse", ep_a, 0);
    for (int c = 0; c < 4; c++) begin
      sel_a = 2'(c);
      #1 check($sformatf("idle_count%0d", c), cnt_a, 0);
    end
    // Latency: new level sampled on edge 1, state flips on edge 6
    do_reset();
    sel_a = 0;
    raw_black[0] = 1'b1;
    tick(5);
    check("lat_before", ls_a[0], 0);
    tick();
    check("lat_state", ls_a, 4'b0001);
    check("lat_pulse", ep_a, 4'b0001);
    check("lat_count", cnt_a, 1);
    check("lat_any", any_a, 1);
    tick();
    check("lat_pulse_off", ep_a, 0);
    // Falling back to white is not counted and gives no pulse
    raw_black[0] = 1'b0;
    tick(6);
    check("fall_state", ls_a[0], 0);
    check("fall_pulse", ep_a[0], 0);
    check("fall_count", cnt_a, 1);
    // Glitch of 3 synced cycles is rejected
    do_reset();
    sel_a = 1;
    raw_black[1] = 1'b1;
    tick(3);
    raw_black[1] = 1'b0;
    tick(10);
    check("glitch_state", ls_a[1], 0);
    check("glitch_count", cnt_a, 0);
    stripe(1, 5);
    check("stripe_count", cnt_a, 5);
    check("stripe_flag", flag_a, 0);
    // Narrow counters: saturate holds at 3, wrap goes 3->0->1, both flag
    do_reset();
    sel_s = 0; sel_w = 0;
    stripe(0, 5);
    check("sat_count", cnt_s, 3);
    check("sat_flag", flag_s, 1);
    check("wrap_count", cnt_w, 1);
    check("wrap_flag", flag_w, 1);
    sel_s = 3;
    #1 check("oor_count", cnt_s, 0);
    check("oor_flag", flag_s, 0);
    // Plain clear empties count and flag
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    sel_w = 0;
    #1 check("clr_count", cnt_w, 0);
    check("clr_flag", flag_w, 0);
    // Clear coinciding with the 6->7 increment keeps the event
    do_reset();
    sel_a = 2;
    stripe(2, 6);
    check("pre_clr_count", cnt_a, 6);
    raw_black[2] = 1'b1;
    tick(5);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    check("clrinc_pulse", ep_a[2], 1);
    check("clrinc_count", cnt_a, 1);
    check("clrinc_flag", flag_a, 0);
    raw_black[2] = 1'b0;
    tick(8);
    // Simultaneous events on two channels both count
    sel_a = 3;
    raw_black[3] = 1'b1; raw_black[2] = 1'b1;
    tick(6);
    check("multi_pulse", ep_a, 4'b1100);
    check("multi_count3", cnt_a, 1);
    sel_a = 2;
    #1 check("multi_count2", cnt_a, 2);
    // Reset mid-debounce wipes everything and debounce restarts from scratch
    do_reset();
    sel_a = 0;
    stripe(0, 9);
    check("pre_rst_count", cnt_a, 9);
    raw_black[0] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_state", ls_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_pulse", ep_a, 0);
    check("rst_any", any_a, 0);
    tick(5);
    check("rst_restart_before", ls_a[0], 0);
    tick();
    check("rst_restart_state", ls_a[0], 1);
    check("rst_restart_count", cnt_a, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
